// File: rtl/cp0_exception_commit.sv
// CP0 exception/ERET commit: updates EPC/Cause/Status/BadVAddr, flushes the pipeline,
// then hands a redirect PC to IF over a valid/ready handshake.
module cp0_exception_commit #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_req,
   input  logic [4:0]  exc_code,
   input  logic        exc_badvaddr_we,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret_req,
   input  logic [31:0] vic_inst_addr,
   input  logic        vic_is_delayslot,
   input  logic [7:0]  exp_asid,
   input  logic [5:0]  hw_int,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic [7:0]  exc_asid_o,
   output logic        int_pending
);

   typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

   // Status: IE=0, EXL=1, IM=15:8, BEV=22. Cause: ExcCode=6:2, IP=15:8, BD=31.
   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
   localparam logic [3:0]  FLUSH_LAST   = 4'(FLUSH_CYCLES - 1);

   state_t     state;
   logic [3:0] flush_cnt;
   logic       take_trap;
   logic       take_eret;

   assign int_pending = (|(cause_o[15:8] & status_o[15:8])) & status_o[0] & ~status_o[1];

   always_comb begin
      take_trap = 1'b0;
      take_eret = 1'b0;
      if (state == IDLE) begin
         take_trap = exc_req | int_pending;
         take_eret = ~take_trap & eret_req;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: every CP0 register is architecturally visible, so all of them are reset; no storage array here.
      if (rst) begin
         state          <= IDLE;
         flush_cnt      <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         status_o       <= STATUS_RESET;
         cause_o        <= '0;
         epc_o          <= '0;
         badvaddr_o     <= '0;
         exc_asid_o     <= '0;
      end else begin
         if (cp0_we) begin
            unique case (cp0_waddr)
               5'd12:   status_o      <= cp0_wdata;
               5'd13:   cause_o[9:8]  <= cp0_wdata[9:8];
               5'd14:   epc_o         <= cp0_wdata;
               default: ;
            endcase
         end
         cause_o[15:10] <= hw_int;

         // NOTE: the commit updates below are written after MTC0 on purpose; with non-blocking
         // assignments the last write to a bit wins, which gives acceptance priority on the same edge.
         unique case (state)
            IDLE: begin
               if (take_trap) begin
                  if (!status_o[1]) begin
                     epc_o       <= vic_is_delayslot ? vic_inst_addr - 32'd4 : vic_inst_addr;
                     cause_o[31] <= vic_is_delayslot;
                  end
                  cause_o[6:2] <= exc_req ? exc_code : 5'd0;
                  status_o[1]  <= 1'b1;
                  exc_asid_o   <= exp_asid;
                  if (exc_req && exc_badvaddr_we) badvaddr_o <= exc_badvaddr;
                  redirect_pc  <= EXC_VECTOR;
               end else if (take_eret) begin
                  status_o[1]  <= 1'b0;
                  redirect_pc  <= epc_o;
               end
               if (take_trap || take_eret) begin
                  state     <= DRAIN;
                  flush     <= 1'b1;
                  flush_cnt <= FLUSH_LAST;
               end
            end
            DRAIN: begin
               if (flush_cnt == 4'd0) begin
                  state          <= REDIRECT;
                  flush          <= 1'b0;
                  redirect_valid <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  state          <= IDLE;
                  redirect_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exception_commit.sv
// Directed bench for cp0_exception_commit; a scoreboard queue holds expected redirect PCs
// and a monitor compares them (plus flush length) at each redirect handshake.
module tb_cp0_exception_commit;

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_req, exc_badvaddr_we, eret_req, vic_is_delayslot, cp0_we, redirect_ready;
   logic [4:0]  exc_code, cp0_waddr;
   logic [31:0] exc_badvaddr, vic_inst_addr, cp0_wdata;
   logic [7:0]  exp_asid;
   logic [5:0]  hw_int;
   logic        flush, redirect_valid, int_pending;
   logic [31:0] redirect_pc, status_o, cause_o, epc_o, badvaddr_o;
   logic [7:0]  exc_asid_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   int flush_run = 0;

   always #5 clk = ~clk;

   cp0_exception_commit dut (
      .clk(clk), .rst(rst), .exc_req(exc_req), .exc_code(exc_code),
      .exc_badvaddr_we(exc_badvaddr_we), .exc_badvaddr(exc_badvaddr), .eret_req(eret_req),
      .vic_inst_addr(vic_inst_addr), .vic_is_delayslot(vic_is_delayslot), .exp_asid(exp_asid),
      .hw_int(hw_int), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
      .redirect_ready(redirect_ready), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .badvaddr_o(badvaddr_o), .exc_asid_o(exc_asid_o), .int_pending(int_pending)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: compares each redirect handshake against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            flush_run = 0;
         end else begin
            if (flush) flush_run++;
            if (redirect_valid && redirect_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
               end else begin
                  check("redirect_pc", redirect_pc, exp_q.pop_front());
                  check("flush_len", 32'(flush_run), 32'd2);
               end
               flush_run = 0;
            end
         end
      end
   end

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      cp0_we = 1'b1; cp0_waddr = addr; cp0_wdata = data;
      @(posedge clk); #1;
      cp0_we = 1'b0;
   endtask

   task automatic issue_exc(input logic [4:0] code, input logic [31:0] addr, input logic ds,
                            input logic bv_we, input logic [31:0] bva, input logic [7:0] asid);
      @(negedge clk);
      exc_req = 1'b1; exc_code = code; vic_inst_addr = addr; vic_is_delayslot = ds;
      exc_badvaddr_we = bv_we; exc_badvaddr = bva; exp_asid = asid;
      exp_q.push_back(VEC);
      @(posedge clk); #1;
      exc_req = 1'b0; exc_badvaddr_we = 1'b0;
      check("flush_after_accept", 32'(flush), 32'd1);
   endtask

   task automatic wait_handshake(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (redirect_valid && redirect_ready) done = 1'b1;
      end
      if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      check({name, "_valid_drop"}, 32'(redirect_valid), 32'd0);
   endtask

   task automatic wait_valid(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (redirect_valid) seen = 1'b1;
      end
      if (!seen) check({name, "_valid_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; exc_req = 0; exc_code = 0; exc_badvaddr_we = 0; exc_badvaddr = 0; eret_req = 0;
      vic_inst_addr = 0; vic_is_delayslot = 0; exp_asid = 0; hw_int = 0; cp0_we = 0; cp0_waddr = 0;
      cp0_wdata = 0; redirect_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_status", status_o, 32'h0040_0000);
      check("rst_cause", cause_o, 32'd0);
      check("rst_epc", epc_o, 32'd0);
      check("rst_badvaddr", badvaddr_o, 32'd0);
      check("rst_asid", 32'(exc_asid_o), 32'd0);
      check("rst_outs", {29'd0, flush, redirect_valid, int_pending}, 32'd0);
      check("rst_rpc", redirect_pc, 32'd0);

      // Plain exception with bad address.
      issue_exc(5'd4, 32'h8000_1000, 1'b0, 1'b1, 32'h1234_5671, 8'h11);
      wait_handshake("exc1");
      check("exc1_epc", epc_o, 32'h8000_1000);
      check("exc1_code", 32'(cause_o[6:2]), 32'd4);
      check("exc1_badvaddr", badvaddr_o, 32'h1234_5671);
      check("exc1_exl", 32'(status_o[1]), 32'd1);
      check("exc1_asid", 32'(exc_asid_o), 32'h11);

      // Delay-slot exception after clearing EXL.
      mtc0(5'd12, 32'h0040_0000);
      issue_exc(5'd10, 32'h8000_2004, 1'b1, 1'b0, 32'd0, 8'h22);
      wait_handshake("exc_ds");
      check("ds_epc", epc_o, 32'h8000_2000);
      check("ds_bd", 32'(cause_o[31]), 32'd1);

      // Nested exception: EPC/BD frozen, ExcCode updated.
      issue_exc(5'd12, 32'h8000_3000, 1'b0, 1'b0, 32'd0, 8'h33);
      wait_handshake("exc_nested");
      check("nest_epc", epc_o, 32'h8000_2000);
      check("nest_bd", 32'(cause_o[31]), 32'd1);
      check("nest_code", 32'(cause_o[6:2]), 32'd12);
      check("nest_badvaddr", badvaddr_o, 32'h1234_5671);

      // ERET with IF stalling the redirect for 3 cycles.
      mtc0(5'd14, 32'h8000_0040);
      redirect_ready = 1'b0;
      @(negedge clk);
      eret_req = 1'b1;
      exp_q.push_back(32'h8000_0040);
      @(posedge clk); #1;
      eret_req = 1'b0;
      check("eret_exl", 32'(status_o[1]), 32'd0);
      wait_valid("eret");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("eret_hold_valid", 32'(redirect_valid), 32'd1);
         check("eret_hold_pc", redirect_pc, 32'h8000_0040);
      end
      @(posedge clk); #1 redirect_ready = 1'b1;
      wait_handshake("eret");

      // Interrupt taken from IDLE with ExcCode 0.
      mtc0(5'd12, 32'h0040_0401);
      @(negedge clk);
      hw_int = 6'b000001; vic_inst_addr = 32'h8000_4000; vic_is_delayslot = 1'b0; exp_asid = 8'h44;
      exp_q.push_back(VEC);
      @(posedge clk); #1;
      check("int_pending_set", 32'(int_pending), 32'd1);
      @(posedge clk); #1;
      check("int_flush", 32'(flush), 32'd1);
      wait_handshake("int");
      check("int_code", 32'(cause_o[6:2]), 32'd0);
      check("int_epc", epc_o, 32'h8000_4000);
      check("int_asid", 32'(exc_asid_o), 32'h44);
      check("int_masked_by_exl", 32'(int_pending), 32'd0);

      // Exception and pending interrupt together: exception wins.
      @(negedge clk) hw_int = 6'b0;
      mtc0(5'd12, 32'h0040_0401);
      @(negedge clk) hw_int = 6'b000001;
      @(posedge clk); #1;
      check("both_int_pending", 32'(int_pending), 32'd1);
      exc_req = 1'b1; exc_code = 5'd8; vic_inst_addr = 32'h8000_5000; vic_is_delayslot = 1'b0;
      exp_asid = 8'h55;
      exp_q.push_back(VEC);
      @(posedge clk); #1;
      exc_req = 1'b0;
      wait_handshake("both");
      check("both_code", 32'(cause_o[6:2]), 32'd8);
      check("both_epc", epc_o, 32'h8000_5000);
      hw_int = 6'b0;

      // Reset while the redirect is waiting.
      redirect_ready = 1'b0;
      issue_exc(5'd5, 32'h8000_6000, 1'b0, 1'b0, 32'd0, 8'h66);
      wait_valid("rst_mid");
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstmid_valid", 32'(redirect_valid), 32'd0);
      check("rstmid_status", status_o, 32'h0040_0000);
      check("rstmid_flush", 32'(flush), 32'd0);
      redirect_ready = 1'b1;

      // MTC0 field masking and unused addresses.
      mtc0(5'd13, 32'hFFFF_FFFF);
      check("cause_ip_sw", cause_o, 32'h0000_0300);
      mtc0(5'd5, 32'hDEAD_BEEF);
      check("ignored_epc", epc_o, 32'd0);
      check("ignored_status", status_o, 32'h0040_0000);

      // Same-edge MTC0 EPC loses to acceptance; EPC arithmetic wraps.
      @(negedge clk);
      cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
      exc_req = 1'b1; exc_code = 5'd6; vic_inst_addr = 32'h0000_0002; vic_is_delayslot = 1'b1;
      exp_q.push_back(VEC);
      @(posedge clk); #1;
      cp0_we = 1'b0; exc_req = 1'b0;
      wait_handshake("wrap");
      check("wrap_epc", epc_o, 32'hFFFF_FFFE);
      check("wrap_bd", 32'(cause_o[31]), 32'd1);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
